// File: rtl/pt2262_pkg.sv
// Shared definitions for the PT2262 encoder and the PT2272 decoder:
// symbol and state encodings, alpha-based timing constants, pin mapping.
package pt2262_pkg;

  typedef enum logic [1:0] {
    SYM_0    = 2'd0,
    SYM_1    = 2'd1,
    SYM_F    = 2'd2,
    SYM_SYNC = 2'd3
  } sym_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BITS = 2'd1,
    SYNC = 2'd2
  } enc_state_t;

  // Timing in osc cycles (one cycle = one alpha)
  localparam int unsigned T_SHORT   = 4;
  localparam int unsigned T_LONG    = 12;
  localparam int unsigned T_HALF    = 16;
  localparam int unsigned T_BIT     = 32;
  localparam int unsigned T_SYNC    = 128;
  localparam int unsigned N_SYMBOLS = 12;

  localparam int unsigned N_ADDR  = 8;
  localparam int unsigned N_DATA  = 4;
  localparam int unsigned PHASE_W = 7;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned WCNT_W  = 4;

  // Trinary address pin: floating wins over the driven value
  function automatic sym_t pin_symbol(input logic val, input logic flt);
    if (flt) return SYM_F;
    return val ? SYM_1 : SYM_0;
  endfunction

endpackage

// File: rtl/pt2262_symbol_shaper.sv
// Combinational waveform generator: output level for a symbol at a phase.
// Bit symbols are two 16-cycle halves, short (4H/12L) or long (12H/4L);
// SYNC is 4H followed by 124L.
module pt2262_symbol_shaper
  import pt2262_pkg::*;
(
  input  sym_t               sym,
  input  logic [PHASE_W-1:0] phase,
  output logic               level
);

  logic [3:0] half_pos;
  logic       second_half;
  logic       long_half;

  // Pick half type from the symbol, then compare position against its high time
  always_comb begin
    half_pos    = phase[3:0];
    second_half = phase[4];
    long_half   = 1'b0;
    level       = 1'b0;
    case (sym)
      SYM_0:   long_half = 1'b0;
      SYM_1:   long_half = 1'b1;
      SYM_F:   long_half = second_half;
      default: long_half = 1'b0;
    endcase
    if (sym == SYM_SYNC)
      level = (phase < PHASE_W'(T_SHORT));
    else if (long_half)
      level = (half_pos < 4'(T_LONG));
    else
      level = (half_pos < 4'(T_SHORT));
  end

endmodule

// File: rtl/pt2262_encoder.sv
// PT2262-compatible serial encoder. Sends A0..A7, D0..D3 and SYNC as one
// 512-cycle word, repeating while te is high and for at least MIN_WORDS words.
module pt2262_encoder
  import pt2262_pkg::*;
#(
  parameter int unsigned MIN_WORDS = 4
) (
  input  logic       osc_clk,
  input  logic       reset,
  input  logic [7:0] a_val,
  input  logic [7:0] a_float,
  input  logic [3:0] d,
  input  logic       te,
  output logic       cod_o,
  output logic       busy,
  output logic       word_done
);

  localparam logic [WCNT_W-1:0]  MIN_W      = WCNT_W'(MIN_WORDS);
  localparam logic [WCNT_W-1:0]  WCNT_MAX   = '1;
  localparam logic [PHASE_W-1:0] PH_BIT_END = PHASE_W'(T_BIT - 1);
  localparam logic [PHASE_W-1:0] PH_SYN_END = PHASE_W'(T_SYNC - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(N_SYMBOLS - 1);

  enc_state_t         state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [PHASE_W-1:0] phase, phase_nxt;
  logic [WCNT_W-1:0]  wcnt, wcnt_nxt, wcnt_inc;
  sym_t               syms    [N_SYMBOLS];
  sym_t               in_syms [N_SYMBOLS];
  sym_t               sym_nxt;
  logic               load;
  logic               level;

  // Map live pins to symbols so a word start can latch them
  always_comb begin
    for (int unsigned i = 0; i < N_ADDR; i++)
      in_syms[i] = pin_symbol(a_val[i], a_float[i]);
    for (int unsigned i = 0; i < N_DATA; i++)
      in_syms[N_ADDR + i] = d[i] ? SYM_1 : SYM_0;
  end

  // Next-state logic for state, bit index, phase and word counter
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    phase_nxt = phase;
    wcnt_nxt  = wcnt;
    load      = 1'b0;
    wcnt_inc  = (wcnt == WCNT_MAX) ? wcnt : wcnt + 1'b1;
    case (state)
      IDLE: begin
        if (te) begin
          state_nxt = BITS;
          idx_nxt   = '0;
          phase_nxt = '0;
          wcnt_nxt  = '0;
          load      = 1'b1;
        end
      end
      BITS: begin
        if (phase == PH_BIT_END) begin
          phase_nxt = '0;
          if (idx == IDX_LAST) begin
            state_nxt = SYNC;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end else begin
          phase_nxt = phase + 1'b1;
        end
      end
      SYNC: begin
        if (phase == PH_SYN_END) begin
          phase_nxt = '0;
          idx_nxt   = '0;
          wcnt_nxt  = wcnt_inc;
          if (te || (wcnt_inc < MIN_W)) begin
            state_nxt = BITS;
            load      = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          phase_nxt = phase + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Symbol about to be on air; on a word start it comes straight from the
  // pins so cod_o needs no extra pipeline cycle
  always_comb begin
    if (state_nxt == SYNC)
      sym_nxt = SYM_SYNC;
    else if (load)
      sym_nxt = in_syms[0];
    else
      sym_nxt = syms[idx_nxt];
  end

  pt2262_symbol_shaper u_shaper (
    .sym   (sym_nxt),
    .phase (phase_nxt),
    .level (level)
  );

  // Register FSM state, latched word and outputs
  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      phase     <= '0;
      wcnt      <= '0;
      syms      <= '{default: SYM_0};
      cod_o     <= 1'b0;
      busy      <= 1'b0;
      word_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      phase     <= phase_nxt;
      wcnt      <= wcnt_nxt;
      if (load) syms <= in_syms;
      cod_o     <= (state_nxt != IDLE) && level;
      busy      <= (state_nxt != IDLE);
      word_done <= (state_nxt == SYNC) && (phase_nxt == PH_SYN_END);
    end
  end

endmodule

// File: tb/tb_pt2262_encoder.sv
// Scoreboard bench for pt2262_encoder: a word-level reference model queues
// the expected {cod_o, busy, word_done} per cycle, a monitor compares.
module tb_pt2262_encoder;

  localparam int unsigned MW   = 4;
  localparam int unsigned WLEN = 512;

  logic       osc_clk;
  logic       reset;
  logic [7:0] a_val;
  logic [7:0] a_float;
  logic [3:0] d;
  logic       te;
  logic       cod_o;
  logic       busy;
  logic       word_done;

  int checks = 0;
  int errors = 0;

  pt2262_encoder #(.MIN_WORDS(MW)) dut (
    .osc_clk   (osc_clk),
    .reset     (reset),
    .a_val     (a_val),
    .a_float   (a_float),
    .d         (d),
    .te        (te),
    .cod_o     (cod_o),
    .busy      (busy),
    .word_done (word_done)
  );

  initial begin
    osc_clk = 1'b0;
    forever #5 osc_clk = ~osc_clk;
  end

  // Whole-word waveform straight from the symbol rules
  function automatic logic [WLEN-1:0] build_word(input logic [7:0] av,
                                                 input logic [7:0] af,
                                                 input logic [3:0] dd);
    logic [WLEN-1:0] w;
    logic            long_h [24];
    int              pos;
    int              hi;
    w = '0;
    pos = 0;
    for (int s = 0; s < 8; s++) begin
      if (af[s]) begin
        long_h[2*s] = 1'b0; long_h[2*s+1] = 1'b1;
      end else begin
        long_h[2*s] = av[s]; long_h[2*s+1] = av[s];
      end
    end
    for (int s = 0; s < 4; s++) begin
      long_h[16+2*s] = dd[s];
      long_h[17+2*s] = dd[s];
    end
    for (int h = 0; h < 24; h++) begin
      hi = long_h[h] ? 12 : 4;
      for (int t = 0; t < 16; t++) begin
        w[pos] = (t < hi);
        pos++;
      end
    end
    for (int t = 0; t < 128; t++) begin
      w[pos] = (t < 4);
      pos++;
    end
    return w;
  endfunction

  // Reference model: word position and count, expected outputs queued per edge
  logic [2:0]      exp_q[$];
  logic            m_active = 1'b0;
  int              m_pos    = 0;
  int              m_words  = 0;
  logic [WLEN-1:0] m_wave   = '0;

  always @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      m_active = 1'b0;
      m_pos    = 0;
      m_words  = 0;
      exp_q.delete();
    end else begin
      if (!m_active) begin
        if (te) begin
          m_active = 1'b1;
          m_words  = 0;
          m_pos    = 0;
          m_wave   = build_word(a_val, a_float, d);
        end
      end else begin
        m_pos++;
        if (m_pos == WLEN) begin
          m_words++;
          if (te || m_words < MW) begin
            m_pos  = 0;
            m_wave = build_word(a_val, a_float, d);
          end else begin
            m_active = 1'b0;
            m_pos    = 0;
          end
        end
      end
      exp_q.push_back({m_active && m_wave[m_pos], m_active,
                       m_active && (m_pos == WLEN - 1)});
    end
  end

  // Monitor: compare outputs on the falling edge
  always @(negedge osc_clk) begin
    logic [2:0] e;
    logic [2:0] a;
    a = {cod_o, busy, word_done};
    if (reset) begin
      checks++;
      if (a !== 3'b000) begin
        errors++;
        $display("FAIL reset_out t=%0t actual cod/busy/wd=%b expected=000", $time, a);
      end
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_out t=%0t actual cod/busy/wd=%b expected=%b", $time, a, e);
      end
    end
  end

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_te();
    te = 1'b1;
    @(negedge osc_clk);
    te = 1'b0;
  endtask

  // Count busy cycles and word_done pulses from now until busy drops
  task automatic run_until_idle(output int bc, output int wc);
    bc = 0;
    wc = 0;
    for (int i = 0; i < 40000; i++) begin
      if (!busy) return;
      bc++;
      if (word_done) wc++;
      @(negedge osc_clk);
    end
    checks++;
    errors++;
    $display("FAIL idle_timeout actual busy=%b expected 0", busy);
  endtask

  int bc, wc, bc2, wc2;

  initial begin
    reset   = 1'b1;
    te      = 1'b0;
    a_val   = '0;
    a_float = '0;
    d       = '0;
    repeat (3) @(negedge osc_clk);
    reset = 1'b0;
    repeat (5) @(negedge osc_clk);
    check_int("idle_busy", int'(busy), 0);

    // All-zero address, d=1010, single-cycle te
    a_val = 8'h00; a_float = 8'h00; d = 4'b1010;
    pulse_te();
    run_until_idle(bc, wc);
    check_int("pulse_busy_cycles", bc, MW * WLEN);
    check_int("pulse_word_done", wc, MW);
    repeat (4) @(negedge osc_clk);

    // Floating and high address pins
    a_val = 8'h42; a_float = 8'h81; d = 4'($urandom_range(0, 15));
    pulse_te();
    run_until_idle(bc, wc);
    check_int("float_busy_cycles", bc, MW * WLEN);
    repeat (4) @(negedge osc_clk);

    // te held for 3000 cycles: six words back to back
    a_val = 8'($urandom); a_float = 8'h00; d = 4'h5;
    te = 1'b1;
    bc = 0; wc = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge osc_clk);
      if (busy) bc++;
      if (word_done) wc++;
    end
    te = 1'b0;
    @(negedge osc_clk);
    run_until_idle(bc2, wc2);
    check_int("held_busy_cycles", bc + bc2, 6 * WLEN);
    check_int("held_word_done", wc + wc2, 6);
    repeat (4) @(negedge osc_clk);

    // d changes during word 2; only word 3 carries the new value
    d = 4'h3;
    pulse_te();
    repeat (WLEN + 200) @(negedge osc_clk);
    d = 4'hC;
    run_until_idle(bc, wc);
    check_int("dchange_word_done", wc + 2 - 2, MW - 1);
    repeat (4) @(negedge osc_clk);

    // Asynchronous reset 200 cycles into word 1
    d = 4'h9;
    pulse_te();
    repeat (199) @(negedge osc_clk);
    #2 reset = 1'b1;
    #1;
    check_int("async_reset_cod", int'(cod_o), 0);
    check_int("async_reset_busy", int'(busy), 0);
    @(negedge osc_clk);
    @(negedge osc_clk);
    reset = 1'b0;
    repeat (3) @(negedge osc_clk);
    check_int("post_reset_idle", int'(busy), 0);
    pulse_te();
    run_until_idle(bc, wc);
    check_int("post_reset_busy_cycles", bc, MW * WLEN);
    check_int("post_reset_word_done", wc, MW);

    // Random pins and sparse random te activity
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        a_val   = 8'($urandom);
        a_float = 8'($urandom);
        d       = 4'($urandom);
      end
      te = ($urandom_range(0, 299) == 0);
      @(negedge osc_clk);
    end
    te = 1'b0;
    run_until_idle(bc, wc);
    repeat (4) @(negedge osc_clk);
    check_int("final_idle", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
